iob_eth_buf_rd: RTL and testbench

// Reader side of the Ethernet frame buffer: streams a stored frame out of the
// 32-bit true-dual-port buffer RAM. On a start command it reads words over the
// RAM read-only port (fixed 1-cycle latency), serializes them to bytes and

---
 rtl/iob_eth_buf_rd.sv | 150 +++++++++++++++
 tb/tb_iob_eth_buf_rd.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_buf_rd.sv
// Ethernet frame buffer reader: fetches 32-bit words from the buffer RAM read
// port and streams them out little-endian as a valid/ready byte stream.
module iob_eth_buf_rd #(
   parameter int ADDR_W = 9,
   parameter int LEN_W  = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic              ram_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_dout,
   output logic [7:0]        byte_data,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t             r_state;
   state_t             w_nextState;

   logic [ADDR_W-1:0]  r_addr;
   logic [LEN_W-2:0]   r_wordsLeft;
   logic [LEN_W-1:0]   r_bytesLeft;
   logic [31:0]        r_cur;
   logic [31:0]        r_pf;
   logic               r_curValid;
   logic               r_pfValid;
   logic               r_inflight;
   logic [1:0]         r_lane;

   logic [LEN_W-2:0]   w_wordsNeed;
   logic               w_startOk;
   logic               w_accept;
   logic               w_lastByte;
   logic               w_wordEnd;
   logic               w_curFree;
   logic               w_ramEn;

   // ceil(len/4) without an extra adder bit that would go unused
   assign w_wordsNeed = (LEN_W-1)'(len[LEN_W-1:2]) + (LEN_W-1)'(|len[1:0]);
   assign w_startOk   = (r_state == ST_IDLE) && start;
   assign w_accept    = byte_valid && byte_ready;
   assign w_lastByte  = (r_bytesLeft == LEN_W'(1));
   assign w_wordEnd   = w_accept && ((r_lane == 2'd3) || w_lastByte);
   assign w_curFree   = !r_curValid || w_wordEnd;

   assign ram_addr    = r_addr;
   assign byte_data   = r_cur[{r_lane, 3'b000} +: 8];
   assign byte_valid  = (r_state == ST_RUN) && r_curValid;
   assign byte_last   = byte_valid && w_lastByte;
   assign ram_en      = w_ramEn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      w_ramEn     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_nextState = (len == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            busy    = 1'b1;
            w_ramEn = !r_pfValid && !r_inflight && (r_wordsLeft != '0);
            if (w_accept && w_lastByte) begin
               w_nextState = ST_DONE;
            end
         end
         ST_DONE: begin
            done        = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // A read is only issued with the prefetch slot empty, so returning data can
   // always land in either the current word (bypass) or the prefetch slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr      <= '0;
         r_wordsLeft <= '0;
         r_bytesLeft <= '0;
         r_cur       <= '0;
         r_pf        <= '0;
         r_curValid  <= 1'b0;
         r_pfValid   <= 1'b0;
         r_inflight  <= 1'b0;
         r_lane      <= '0;
      end else if (w_startOk) begin
         r_addr      <= base_addr;
         r_wordsLeft <= w_wordsNeed;
         r_bytesLeft <= len;
         r_curValid  <= 1'b0;
         r_pfValid   <= 1'b0;
         r_inflight  <= 1'b0;
         r_lane      <= '0;
      end else if (r_state == ST_RUN) begin
         r_inflight <= w_ramEn;
         if (w_ramEn) begin
            r_addr      <= r_addr + ADDR_W'(1);
            r_wordsLeft <= r_wordsLeft - (LEN_W-1)'(1);
         end
         if (w_accept) begin
            r_bytesLeft <= r_bytesLeft - LEN_W'(1);
            r_lane      <= r_lane + 2'd1;
         end
         if (w_curFree) begin
            r_lane <= '0;
            if (r_pfValid) begin
               r_cur      <= r_pf;
               r_curValid <= 1'b1;
               r_pfValid  <= 1'b0;
            end else if (r_inflight) begin
               r_cur      <= ram_dout;
               r_curValid <= 1'b1;
            end else begin
               r_curValid <= 1'b0;
            end
         end else if (r_inflight) begin
            r_pf      <= ram_dout;
            r_pfValid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_iob_eth_buf_rd.sv
// Directed bench for iob_eth_buf_rd with a behavioural 1-cycle-latency RAM.
module tb_iob_eth_buf_rd;

   logic        clk;
   logic        rst;
   logic        start;
   logic [8:0]  base_addr;
   logic [10:0] len;
   logic        busy;
   logic        done;
   logic        ram_en;
   logic [8:0]  ram_addr;
   logic [31:0] ram_dout;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        byte_last;

   int total;
   int bad;

   logic [31:0] mem [0:511];
   logic [7:0]  capData  [0:63];
   logic        capLast  [0:63];
   int          capCycle [0:63];
   logic [8:0]  rdAddr   [0:15];
   int nCap, nRd, doneCycle, stableErr, dropErr, pfErr, doneBusyErr;

   iob_eth_buf_rd #(.ADDR_W(9), .LEN_W(11)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .base_addr(base_addr),
      .len(len),
      .busy(busy),
      .done(done),
      .ram_en(ram_en),
      .ram_addr(ram_addr),
      .ram_dout(ram_dout),
      .byte_data(byte_data),
      .byte_valid(byte_valid),
      .byte_ready(byte_ready),
      .byte_last(byte_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) ram_dout <= mem[ram_addr];
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Runs one frame, logging bytes, reads and stream-rule violations; cycle
   // numbers count from the start cycle as cycle 0.
   task automatic collect(input logic [8:0] b, input logic [10:0] l,
                          input bit rnd, input int reStartAt, input int maxCycles);
      logic [7:0] heldData;
      logic       heldLast;
      bit         stalled;
      int         c;
      for (int i = 0; i < 64; i++) begin
         capData[i] = 'x;
         capLast[i] = 'x;
         capCycle[i] = -1;
      end
      for (int i = 0; i < 16; i++) rdAddr[i] = 'x;
      nCap = 0; nRd = 0; doneCycle = -1;
      stableErr = 0; dropErr = 0; pfErr = 0; doneBusyErr = 0;
      stalled = 0; heldData = '0; heldLast = 1'b0;
      @(negedge clk);
      base_addr = b; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (c <= maxCycles) begin
         start = (c == reStartAt);
         if (c == reStartAt) begin
            base_addr = 9'd0;
            len = 11'd3;
         end
         byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ram_en) begin
            if ((nRd - nCap / 4) > 1) pfErr++;
            if (nRd < 16) rdAddr[nRd] = ram_addr;
            nRd++;
         end
         if (stalled) begin
            if (!byte_valid) dropErr++;
            else if (byte_data !== heldData || byte_last !== heldLast) stableErr++;
         end
         if (byte_valid && byte_ready) begin
            if (nCap < 64) begin
               capData[nCap] = byte_data;
               capLast[nCap] = byte_last;
               capCycle[nCap] = c;
            end
            nCap++;
            stalled = 0;
         end else if (byte_valid) begin
            stalled = 1;
            heldData = byte_data;
            heldLast = byte_last;
         end else begin
            stalled = 0;
         end
         if (done) begin
            doneCycle = c;
            if (busy) doneBusyErr++;
            break;
         end
         @(negedge clk);
         c++;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; byte_ready = 1'b0; base_addr = '0; len = '0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, ram_en, byte_valid, byte_last} !== 5'b0 || ram_addr !== 9'd0 || byte_data !== 8'd0) begin
         bad++;
         $display("[TB] FAIL reset_outputs: got flags=%b addr=%0h data=%0h expected all zero",
                  {busy, done, ram_en, byte_valid, byte_last}, ram_addr, byte_data);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, ram_en, byte_valid, byte_last} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL idle_outputs: got flags=%b expected 00000",
                  {busy, done, ram_en, byte_valid, byte_last});
      end
   endtask

   task automatic test_zero_len();
      collect(9'd7, 11'd0, 1'b0, -1, 10);
      total++;
      if (doneCycle !== 1) begin
         bad++;
         $display("[TB] FAIL zero_len_done_cycle: got %0d expected 1", doneCycle);
      end
      total++;
      if (nCap !== 0 || nRd !== 0) begin
         bad++;
         $display("[TB] FAIL zero_len_activity: got bytes=%0d reads=%0d expected 0 0", nCap, nRd);
      end
   endtask

   task automatic test_full_words();
      logic [7:0] exp [0:7];
      exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      collect(9'd0, 11'd8, 1'b0, -1, 40);
      total++;
      if (nCap !== 8) begin
         bad++;
         $display("[TB] FAIL full_count: got %0d expected 8", nCap);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (capData[i] !== exp[i] || capCycle[i] !== 3 + i || capLast[i] !== (i == 7)) begin
            bad++;
            $display("[TB] FAIL full_byte%0d: got data=%0h cycle=%0d last=%b expected %0h %0d %b",
                     i, capData[i], capCycle[i], capLast[i], exp[i], 3 + i, (i == 7));
         end
      end
      total++;
      if (doneCycle !== 11 || doneBusyErr !== 0) begin
         bad++;
         $display("[TB] FAIL full_done: got cycle=%0d busyAtDone=%0d expected 11 0", doneCycle, doneBusyErr);
      end
      total++;
      if (nRd !== 2 || rdAddr[0] !== 9'd0 || rdAddr[1] !== 9'd1) begin
         bad++;
         $display("[TB] FAIL full_reads: got n=%0d a0=%0h a1=%0h expected 2 0 1", nRd, rdAddr[0], rdAddr[1]);
      end
      // a start during the DONE cycle must be dropped
      base_addr = 9'd0; len = 11'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || ram_en !== 1'b0) begin
         bad++;
         $display("[TB] FAIL start_in_done: got busy=%b done=%b ram_en=%b expected 0 0 0", busy, done, ram_en);
      end
   endtask

   task automatic test_partial_word();
      logic [7:0] exp [0:4];
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      collect(9'd4, 11'd5, 1'b0, -1, 40);
      total++;
      if (nCap !== 5 || doneCycle !== 8) begin
         bad++;
         $display("[TB] FAIL partial_count: got bytes=%0d done=%0d expected 5 8", nCap, doneCycle);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (capData[i] !== exp[i] || capLast[i] !== (i == 4)) begin
            bad++;
            $display("[TB] FAIL partial_byte%0d: got data=%0h last=%b expected %0h %b",
                     i, capData[i], capLast[i], exp[i], (i == 4));
         end
      end
      total++;
      if (nRd !== 2 || rdAddr[0] !== 9'd4 || rdAddr[1] !== 9'd5) begin
         bad++;
         $display("[TB] FAIL partial_reads: got n=%0d a0=%0h a1=%0h expected 2 4 5", nRd, rdAddr[0], rdAddr[1]);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp [0:7];
      exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h11, 8'h22, 8'h33, 8'h44};
      collect(9'd511, 11'd8, 1'b0, -1, 40);
      total++;
      if (nRd !== 2 || rdAddr[0] !== 9'd511 || rdAddr[1] !== 9'd0) begin
         bad++;
         $display("[TB] FAIL wrap_reads: got n=%0d a0=%0h a1=%0h expected 2 1ff 0", nRd, rdAddr[0], rdAddr[1]);
      end
      for (int i = 0; i < 8; i++) begin
         total++;
         if (capData[i] !== exp[i]) begin
            bad++;
            $display("[TB] FAIL wrap_byte%0d: got %0h expected %0h", i, capData[i], exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      collect(9'd20, 11'd12, 1'b1, 5, 200);
      total++;
      if (nCap !== 12 || doneCycle < 14) begin
         bad++;
         $display("[TB] FAIL stall_count: got bytes=%0d done=%0d expected 12 >=14", nCap, doneCycle);
      end
      for (int i = 0; i < 12; i++) begin
         exp = 8'((i + 1) * 16 + i);
         total++;
         if (capData[i] !== exp || capLast[i] !== (i == 11)) begin
            bad++;
            $display("[TB] FAIL stall_byte%0d: got data=%0h last=%b expected %0h %b",
                     i, capData[i], capLast[i], exp, (i == 11));
         end
      end
      total++;
      if (stableErr !== 0 || dropErr !== 0) begin
         bad++;
         $display("[TB] FAIL stall_rules: got unstable=%0d dropped=%0d expected 0 0", stableErr, dropErr);
      end
      total++;
      if (pfErr !== 0 || nRd !== 3 || rdAddr[0] !== 9'd20 || rdAddr[2] !== 9'd22) begin
         bad++;
         $display("[TB] FAIL stall_reads: got overfetch=%0d n=%0d a0=%0h a2=%0h expected 0 3 14 16",
                  pfErr, nRd, rdAddr[0], rdAddr[2]);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] exp [0:4];
      exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      byte_ready = 1'b1;
      @(negedge clk);
      base_addr = 9'd0; len = 11'd8; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      total++;
      if (byte_valid !== 1'b1 || byte_data !== 8'h33) begin
         bad++;
         $display("[TB] FAIL midreset_pre: got valid=%b data=%0h expected 1 33", byte_valid, byte_data);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({busy, done, ram_en, byte_valid, byte_last} !== 5'b0 || ram_addr !== 9'd0 || byte_data !== 8'd0) begin
         bad++;
         $display("[TB] FAIL midreset_outputs: got flags=%b addr=%0h data=%0h expected all zero",
                  {busy, done, ram_en, byte_valid, byte_last}, ram_addr, byte_data);
      end
      @(negedge clk);
      rst = 1'b0;
      collect(9'd4, 11'd5, 1'b0, -1, 40);
      total++;
      if (nCap !== 5 || doneCycle !== 8 || nRd !== 2 || rdAddr[0] !== 9'd4) begin
         bad++;
         $display("[TB] FAIL midreset_restart: got bytes=%0d done=%0d reads=%0d a0=%0h expected 5 8 2 4",
                  nCap, doneCycle, nRd, rdAddr[0]);
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (capData[i] !== exp[i]) begin
            bad++;
            $display("[TB] FAIL midreset_byte%0d: got %0h expected %0h", i, capData[i], exp[i]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      for (int i = 0; i < 512; i++) mem[i] = 32'hDEAD0000 | 32'(i);
      mem[0]   = 32'h44332211;
      mem[1]   = 32'h88776655;
      mem[4]   = 32'hDDCCBBAA;
      mem[5]   = 32'h000000EE;
      mem[20]  = 32'h3C2B1A09 - 32'h09090909 + 32'h03020100 + 32'h06060606;
      mem[20]  = 32'h3F2E1D0C - 32'h0C0C0C0C + 32'h33221100 - 32'h22221100 + 32'h00000000;
      mem[20]  = 32'h43322110;
      mem[21]  = 32'h87766554;
      mem[22]  = 32'hCBBAA998;
      mem[511] = 32'hA3A2A1A0;
      test_reset();
      test_zero_len();
      test_full_words();
      test_partial_word();
      test_wrap();
      test_back_to_back();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
